// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - load/run/halt controller for a single-cycle CPU
module cpu_run_ctrl #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int DATA_BASE    = 2048,
    parameter int RESET_HOLD   = 2,
    parameter int STALL_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_seg,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    input  logic [31:0]       cpu_pc,
    input  logic [31:0]       halt_pc,
    input  logic [CNT_W-1:0]  timeout,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic              load_err,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int HC_W = $clog2(RESET_HOLD + 1) + 1;
    localparam int SC_W = $clog2(STALL_CYCLES) + 1;
    // Pointers carry one extra bit so a .data wrap past the top word is visible.
    localparam logic [ADDR_W:0] DATA_BASE_P = (ADDR_W+1)'(DATA_BASE);
    localparam logic [ADDR_W:0] PTR_ONE     = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   text_ptr_q, text_ptr_d;
    logic [ADDR_W:0]   data_ptr_q, data_ptr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              load_err_q, load_err_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [31:0]       prev_pc_q, prev_pc_d;
    logic              have_prev_q, have_prev_d;
    logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [31:0]       halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0]  timeout_q, timeout_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [1:0]        status_q, status_d;

    logic pc_same, halt_hit, stall_hit, timeout_hit;

    assign pc_same     = have_prev_q && (cpu_pc == prev_pc_q);
    assign halt_hit    = (cpu_pc == halt_pc_q);
    assign stall_hit   = pc_same && (stall_cnt_q == SC_W'(STALL_CYCLES - 2));
    assign timeout_hit = (timeout_q != '0) && (cycle_count_q == timeout_q - CNT_W'(1));

    assign ld_ready    = (state_q == S_LOAD);
    assign cpu_reset   = (state_q != S_RUN);
    assign busy        = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign load_err    = load_err_q;
    assign status      = status_q;
    assign cycle_count = cycle_count_q;

    // Next-state, load write path and run-time stop detection.
    always_comb begin
        state_d       = state_q;
        text_ptr_d    = text_ptr_q;
        data_ptr_d    = data_ptr_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        load_err_d    = load_err_q;
        hold_cnt_d    = hold_cnt_q;
        prev_pc_d     = prev_pc_q;
        have_prev_d   = have_prev_q;
        stall_cnt_d   = stall_cnt_q;
        halt_pc_d     = halt_pc_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;
        status_d      = status_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    text_ptr_d    = '0;
                    data_ptr_d    = DATA_BASE_P;
                    halt_pc_d     = halt_pc;
                    timeout_d     = timeout;
                    status_d      = 2'b00;
                    load_err_d    = 1'b0;
                    cycle_count_d = '0;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    if (!ld_seg) begin
                        if (text_ptr_q == DATA_BASE_P) begin
                            load_err_d = 1'b1;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = text_ptr_q[ADDR_W-1:0];
                            mem_wdata_d = ld_data;
                            text_ptr_d  = text_ptr_q + PTR_ONE;
                        end
                    end else begin
                        if (data_ptr_q[ADDR_W]) begin
                            load_err_d = 1'b1;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = data_ptr_q[ADDR_W-1:0];
                            mem_wdata_d = ld_data;
                            data_ptr_d  = data_ptr_q + PTR_ONE;
                        end
                    end
                    if (ld_last) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            S_HOLD: begin
                have_prev_d = 1'b0;
                stall_cnt_d = '0;
                if (hold_cnt_q == HC_W'(RESET_HOLD - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            S_RUN: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                prev_pc_d   = cpu_pc;
                have_prev_d = 1'b1;
                stall_cnt_d = pc_same ? stall_cnt_q + SC_W'(1) : '0;
                if (halt_hit) begin
                    status_d = 2'b01;
                    state_d  = S_DONE;
                end else if (stall_hit) begin
                    status_d = 2'b10;
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    status_d = 2'b11;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async reset returns everything to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            text_ptr_q    <= '0;
            data_ptr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            load_err_q    <= 1'b0;
            hold_cnt_q    <= '0;
            prev_pc_q     <= '0;
            have_prev_q   <= 1'b0;
            stall_cnt_q   <= '0;
            halt_pc_q     <= '0;
            timeout_q     <= '0;
            cycle_count_q <= '0;
            status_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            text_ptr_q    <= text_ptr_d;
            data_ptr_q    <= data_ptr_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            load_err_q    <= load_err_d;
            hold_cnt_q    <= hold_cnt_d;
            prev_pc_q     <= prev_pc_d;
            have_prev_q   <= have_prev_d;
            stall_cnt_q   <= stall_cnt_d;
            halt_pc_q     <= halt_pc_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
            status_q      <= status_d;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_seg = 1'b0;
    logic        ld_last = 1'b0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic [31:0] cpu_pc = '0;
    logic [31:0] halt_pc_i = '0;
    logic [31:0] timeout_i = '0;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic        load_err;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [11:0] last_addr = '0;
    logic [31:0] last_data = '0;

    cpu_run_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_seg(ld_seg), .ld_last(ld_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .halt_pc(halt_pc_i),
        .timeout(timeout_i), .busy(busy), .done(done), .status(status),
        .load_err(load_err), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = mem_addr;
            last_data = mem_wdata;
        end
    end

    typedef struct {
        logic        start, valid, seg, last;
        logic [31:0] data, pc;
        logic        e_ready, e_we;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_crst, e_busy, e_done;
        logic [1:0]  e_status;
        logic [31:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] h, input logic [31:0] t);
        @(negedge clk);
        wr_cnt = 0;
        start = 1'b1; halt_pc_i = h; timeout_i = t;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic seg, input logic last, input logic [31:0] d);
        ld_valid = 1'b1; ld_seg = seg; ld_last = last; ld_data = d;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // mode 0: pc steps by 4; mode 1: pc sticks at 0x8; mode 2: steps, with a start pulse mid-run
    task automatic run_to_done(input int mode);
        int k;
        k = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) break;
            start = 1'b0;
            if (!cpu_reset) begin
                if (mode == 1) cpu_pc = (k < 2) ? 32'(4 * k) : 32'h8;
                else           cpu_pc = 32'(4 * k);
                if (mode == 2 && k == 5) start = 1'b1;
                k = k + 1;
            end
        end
        start = 1'b0;
        check("run_reaches_done", {127'b0, done}, 128'd1);
    endtask

    initial begin
        vecs[0]  = '{1,0,0,0, 32'h0, 32'h0,         0,0,12'd0,32'h0,         1,0,0,2'd0,32'd0,0};
        vecs[1]  = '{0,1,0,0, 32'hA0A0_0001, 32'h0, 1,0,12'd0,32'h0,         1,1,0,2'd0,32'd0,0};
        vecs[2]  = '{0,1,0,0, 32'hB0B0_0002, 32'h0, 1,1,12'd0,32'hA0A0_0001, 1,1,0,2'd0,32'd0,0};
        vecs[3]  = '{0,1,0,1, 32'hC0C0_0003, 32'h0, 1,1,12'd1,32'hB0B0_0002, 1,1,0,2'd0,32'd0,0};
        vecs[4]  = '{0,0,0,0, 32'h0, 32'h0,         0,1,12'd2,32'hC0C0_0003, 1,1,0,2'd0,32'd0,0};
        vecs[5]  = '{0,0,0,0, 32'h0, 32'h0,         0,0,12'd0,32'h0,         1,1,0,2'd0,32'd0,0};
        vecs[6]  = '{0,0,0,0, 32'h0, 32'h0,         0,0,12'd0,32'h0,         0,1,0,2'd0,32'd0,0};
        vecs[7]  = '{0,0,0,0, 32'h0, 32'h4,         0,0,12'd0,32'h0,         0,1,0,2'd0,32'd1,0};
        vecs[8]  = '{0,0,0,0, 32'h0, 32'h8,         0,0,12'd0,32'h0,         0,1,0,2'd0,32'd2,0};
        vecs[9]  = '{0,0,0,0, 32'h0, 32'hC,         0,0,12'd0,32'h0,         0,1,0,2'd0,32'd3,0};
        vecs[10] = '{0,0,0,0, 32'h0, 32'h10,        0,0,12'd0,32'h0,         0,1,0,2'd0,32'd4,0};
        vecs[11] = '{0,0,0,0, 32'h0, 32'h10,        0,0,12'd0,32'h0,         1,0,1,2'd1,32'd5,0};
        vecs[12] = '{0,1,0,0, 32'h0, 32'h10,        0,0,12'd0,32'h0,         1,0,1,2'd1,32'd5,0};

        // Reset values
        #12;
        check("reset_values",
              {44'b0, ld_ready, mem_we, busy, done, load_err, status, mem_addr, mem_wdata, cycle_count, cpu_reset},
              {44'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'd0, 32'd0, 32'd0, 1'b1});
        @(negedge clk);
        reset = 1'b0;
        halt_pc_i = 32'h10; timeout_i = 32'd0;

        // T1/T3: three-beat load, reset hold, run to halt at 0x10
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {44'b0, ld_ready, mem_we, vecs[i].e_we ? mem_addr : 12'd0, vecs[i].e_we ? mem_wdata : 32'd0,
                   cpu_reset, busy, done, status, cycle_count, load_err},
                  {44'b0, vecs[i].e_ready, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata,
                   vecs[i].e_crst, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_status, vecs[i].e_cnt, vecs[i].e_err});
            start = vecs[i].start; ld_valid = vecs[i].valid; ld_seg = vecs[i].seg;
            ld_last = vecs[i].last; ld_data = vecs[i].data; cpu_pc = vecs[i].pc;
        end
        @(negedge clk);
        check("dont_ack_outside_load", {126'b0, mem_we, ld_ready}, 128'd0);
        ld_valid = 1'b0;

        // T2: text beat then data beat; start from DONE clears status/count
        do_start(32'hFFFF_FFF0, 32'd8);
        check("done_start_clears", {92'b0, status, cycle_count, busy, done}, {92'b0, 2'b00, 32'd0, 1'b1, 1'b0});
        beat(1'b0, 1'b0, 32'h1111_0000);
        beat(1'b1, 1'b1, 32'hDDDD_0001);
        @(negedge clk);
        check("data_write", {63'b0, wr_cnt[7:0], last_addr, last_data, load_err},
              {63'b0, 8'd2, 12'd2048, 32'hDDDD_0001, 1'b0});
        run_to_done(0);
        check("short_timeout", {94'b0, status, cycle_count}, {94'b0, 2'b11, 32'd8});

        // T4: stuck PC -> stall
        do_start(32'hFFFF_FFF0, 32'd0);
        beat(1'b0, 1'b1, 32'h1);
        run_to_done(1);
        check("stall", {94'b0, status, cycle_count}, {94'b0, 2'b10, 32'd6});

        // T5: timeout, with a start pulse during RUN that must be ignored
        do_start(32'hFFFF_FFF0, 32'd20);
        beat(1'b0, 1'b1, 32'h2);
        run_to_done(2);
        check("timeout", {94'b0, status, cycle_count}, {94'b0, 2'b11, 32'd20});
        check("done_cpu_reset", {126'b0, cpu_reset, busy}, {126'b0, 1'b1, 1'b0});

        // T5b: halt on the same cycle as timeout wins
        do_start(32'd76, 32'd20);
        beat(1'b0, 1'b1, 32'h3);
        run_to_done(0);
        check("halt_beats_timeout", {94'b0, status, cycle_count}, {94'b0, 2'b01, 32'd20});

        // T6: 2049 text beats overflow the text segment, then reset mid-run
        do_start(32'hFFFF_FFF0, 32'd0);
        for (int i = 0; i < 2049; i++) beat(1'b0, i == 2048, 32'(i));
        check("text_overflow_err", {127'b0, load_err}, 128'd1);
        @(negedge clk);
        check("text_overflow_writes", {52'b0, wr_cnt[31:0], last_addr, last_data},
              {52'b0, 32'd2048, 12'd2047, 32'd2047});
        for (int n = 0; n < 10 && cpu_reset; n++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cpu_pc = 32'(4 * k);
            @(negedge clk);
        end
        check("in_run", {125'b0, cpu_reset, busy, load_err}, {125'b0, 1'b0, 1'b1, 1'b1});
        reset = 1'b1;
        #1;
        check("async_reset_mid_run", {122'b0, cpu_reset, busy, done, status, load_err},
              {122'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
